// File: rtl/shared_sram_arbiter.sv
// Shared SRAM arbiter: grants the single external SRAM port to either the instruction-fetch
// requester or the MEM-stage data requester, runs a fixed wait-stated access, then pulses the
// owner's ready for one cycle.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   if_req_i/if_addr_i  fetch request (held until if_ready_o) and byte address
//   if_rdata_o          last fetched word; if_ready_o one-cycle completion pulse
//   d_req_i/d_we_i      data request (held until d_ready_o); 1 = store, 0 = load
//   d_addr_i/d_wdata_i  data byte address and store data
//   d_rdata_o           last loaded word; d_ready_o one-cycle completion pulse
//   sram_*_o            SRAM enable, write enable, word-aligned address, write data
//   sram_rdata_i        SRAM read data, valid in the last access cycle
//   grant_data_o        current or most recent owner (1 = data, 0 = fetch)
module shared_sram_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = 4,
    parameter int unsigned CNT_W       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ready_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_ready_o,
    output logic              sram_en_o,
    output logic              sram_we_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [DATA_W-1:0] sram_wdata_o,
    input  logic [DATA_W-1:0] sram_rdata_i,
    output logic              grant_data_o
);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } state_e;

    localparam logic [CNT_W-1:0]  CntLast   = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(3);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // Owner of the current access; between accesses it is the last owner, which is what
    // the round-robin tie-break needs, so one register serves both roles.
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              grant_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            owner_q    <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        grant_data = 1'b0;
        sram_en_o  = 1'b0;
        sram_we_o  = 1'b0;
        if_ready_o = 1'b0;
        d_ready_o  = 1'b0;

        case (state_q)
            StIdle: begin
                if (if_req_i || d_req_i) begin
                    // Under contention the requester that did not own the last access wins.
                    grant_data = d_req_i && (!if_req_i || !owner_q);
                    owner_d    = grant_data;
                    cnt_d      = '0;
                    state_d    = StAccess;
                    if (grant_data) begin
                        addr_d  = d_addr_i & AlignMask;
                        we_d    = d_we_i;
                        wdata_d = d_wdata_i;
                    end else begin
                        addr_d  = if_addr_i & AlignMask;
                    end
                end
            end
            StAccess: begin
                sram_en_o = 1'b1;
                sram_we_o = owner_q && we_q;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CntLast) begin
                    if (!owner_q) begin
                        if_rdata_d = sram_rdata_i;
                    end else if (!we_q) begin
                        d_rdata_d = sram_rdata_i;
                    end
                    state_d = StDone;
                end
            end
            StDone: begin
                if_ready_o = !owner_q;
                d_ready_o  = owner_q;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign sram_addr_o  = addr_q;
    assign sram_wdata_o = wdata_q;
    assign if_rdata_o   = if_rdata_q;
    assign d_rdata_o    = d_rdata_q;
    assign grant_data_o = owner_q;

endmodule

// File: tb/tb_shared_sram_arbiter.sv
// Testbench for shared_sram_arbiter: per-cycle vector table plus a contention sequence.
module tb_shared_sram_arbiter;

    localparam logic [31:0] I0 = 32'hE3A0_0014;  // word at 0x000
    localparam logic [31:0] I2 = 32'h1234_5678;  // word at 0x008
    localparam logic [31:0] D0 = 32'hCAFE_0001;  // word at 0x400 before the store

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        sram_en;
    logic        sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        grant_data;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    logic [31:0] mem [0:1023];

    shared_sram_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .WAIT_CYCLES(4),
        .CNT_W      (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_rdata_o  (if_rdata),
        .if_ready_o  (if_ready),
        .d_req_i     (d_req),
        .d_we_i      (d_we),
        .d_addr_i    (d_addr),
        .d_wdata_i   (d_wdata),
        .d_rdata_o   (d_rdata),
        .d_ready_o   (d_ready),
        .sram_en_o   (sram_en),
        .sram_we_o   (sram_we),
        .sram_addr_o (sram_addr),
        .sram_wdata_o(sram_wdata),
        .sram_rdata_i(sram_rdata),
        .grant_data_o(grant_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // SRAM model: combinational read, synchronous write.
    assign sram_rdata = mem[sram_addr[11:2]];
    always @(posedge clk) begin
        if (sram_en && sram_we) mem[sram_addr[11:2]] <= sram_wdata;
    end

    typedef struct {
        logic        rst;
        logic        ifr;
        logic [31:0] ifa;
        logic        dr;
        logic        dwe;
        logic [31:0] da;
        logic [31:0] dwd;
        logic        en;
        logic        we;
        logic [31:0] addr;
        logic        ifrdy;
        logic        drdy;
        logic        grant;
        logic [31:0] ifrd;
        logic [31:0] drd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int n, input logic r, input logic ifr, input logic [31:0] ifa,
                       input logic dr, input logic dwe, input logic [31:0] da,
                       input logic [31:0] dwd, input logic en, input logic we,
                       input logic [31:0] addr, input logic ifrdy, input logic drdy,
                       input logic grant, input logic [31:0] ifrd, input logic [31:0] drd);
        vec_t v;
        v = '{r, ifr, ifa, dr, dwe, da, dwd, en, we, addr, ifrdy, drdy, grant, ifrd, drd};
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
        end
    endtask

    // Waits for the next ready pulse; which = 1 data, 0 fetch, -1 timeout.
    task automatic wait_ready(output int which, output int cyc);
        which = -1;
        cyc   = -1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            chk("ready_exclusive", cycle, {31'd0, if_ready & d_ready}, 32'd0);
            if (d_ready || if_ready) begin
                which = d_ready ? 1 : 0;
                cyc   = cycle;
                break;
            end
        end
    endtask

    initial begin
        int which;
        int cyc;
        int prev;

        for (int i = 0; i < 1024; i++) mem[i] <= '0;
        mem[0]     <= I0;
        mem[2]     <= I2;
        mem[10'h100] <= D0;

        // n  rst ifr ifa dr dwe da dwd | en we addr ifrdy drdy grant ifrd drd
        // Single fetch.
        add(1, 1, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0);
        add(4, 0, 1, 0, 0, 0, 0, 0,            1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0, 0,            0, 0, 0, 1, 0, 0, I0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, I0, 0);
        // Simultaneous requests after reset: data first, then fetch.
        add(1, 1, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 1, 0, 'h400, 0,        0, 0, 0, 0, 0, 0, 0, 0);
        add(4, 0, 1, 0, 1, 0, 'h400, 0,        1, 0, 'h400, 0, 0, 1, 0, 0);
        add(1, 0, 1, 0, 1, 0, 'h400, 0,        0, 0, 0, 0, 1, 1, 0, D0);
        add(1, 0, 1, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 1, 0, D0);
        add(4, 0, 1, 0, 0, 0, 0, 0,            1, 0, 0, 0, 0, 0, 0, D0);
        add(1, 0, 1, 0, 0, 0, 0, 0,            0, 0, 0, 1, 0, 0, I0, D0);
        // Store to an unaligned address; d_rdata must not change.
        add(1, 0, 0, 0, 1, 1, 'h403, 'h2000,   0, 0, 0, 0, 0, 0, I0, D0);
        add(4, 0, 0, 0, 1, 1, 'h403, 'h2000,   1, 1, 'h400, 0, 0, 1, I0, D0);
        add(1, 0, 0, 0, 1, 1, 'h403, 'h2000,   0, 0, 0, 0, 1, 1, I0, D0);
        add(1, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 1, I0, D0);
        // Fetch dropped and re-addressed mid-access.
        add(1, 0, 1, 8, 0, 0, 0, 0,            0, 0, 0, 0, 0, 1, I0, D0);
        add(1, 0, 1, 8, 0, 0, 0, 0,            1, 0, 8, 0, 0, 0, I0, D0);
        add(3, 0, 0, 'h40, 0, 0, 0, 0,         1, 0, 8, 0, 0, 0, I0, D0);
        add(1, 0, 0, 'h40, 0, 0, 0, 0,         0, 0, 0, 1, 0, 0, I2, D0);
        add(2, 0, 0, 'h40, 0, 0, 0, 0,         0, 0, 0, 0, 0, 0, I2, D0);
        // Reset in the second access cycle of a store, then a fresh fetch.
        add(1, 0, 0, 0, 1, 1, 'h800, 'h5555,   0, 0, 0, 0, 0, 0, I2, D0);
        add(1, 0, 0, 0, 1, 1, 'h800, 'h5555,   1, 1, 'h800, 0, 0, 1, I2, D0);
        add(1, 1, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0);
        add(4, 0, 1, 0, 0, 0, 0, 0,            1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0, 0,            0, 0, 0, 1, 0, 0, I0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, I0, 0);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            rst     = vecs[i].rst;
            if_req  = vecs[i].ifr;
            if_addr = vecs[i].ifa;
            d_req   = vecs[i].dr;
            d_we    = vecs[i].dwe;
            d_addr  = vecs[i].da;
            d_wdata = vecs[i].dwd;
            @(negedge clk);
            chk("sram_en", i, {31'd0, sram_en}, {31'd0, vecs[i].en});
            chk("sram_we", i, {31'd0, sram_we}, {31'd0, vecs[i].we});
            if (vecs[i].en) chk("sram_addr", i, sram_addr, vecs[i].addr);
            chk("if_ready", i, {31'd0, if_ready}, {31'd0, vecs[i].ifrdy});
            chk("d_ready", i, {31'd0, d_ready}, {31'd0, vecs[i].drdy});
            chk("grant_data", i, {31'd0, grant_data}, {31'd0, vecs[i].grant});
            chk("if_rdata", i, if_rdata, vecs[i].ifrd);
            chk("d_rdata", i, d_rdata, vecs[i].drd);
            chk("ready_exclusive", i, {31'd0, if_ready & d_ready}, 32'd0);
        end

        chk("store_mem_0x400", 0, mem[10'h100], 32'h0000_2000);

        // Continuous contention: grants alternate data, fetch, data, fetch, one per 6 cycles.
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        if_req  = 1'b1;
        if_addr = 32'h0;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h400;
        prev    = 0;
        for (int k = 0; k < 4; k++) begin
            wait_ready(which, cyc);
            chk("alternation_owner", k, which, (k % 2 == 0) ? 1 : 0);
            if (k == 0) chk("load_after_store", k, d_rdata, 32'h0000_2000);
            if (k == 1) chk("fetch_under_contention", k, if_rdata, I0);
            if (k > 0) chk("back_to_back_spacing", k, cyc - prev, 6);
            prev = cyc;
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shared_sram_arbiter.md
Name: shared_sram_arbiter

Overview:
Arbitrates the single external SRAM port between the instruction-fetch stage and the MEM-stage data path. Each requester holds a request until it receives a one-cycle ready pulse. The pipeline freeze logic uses `if_req && !if_ready` and `d_req && !d_ready` as stall terms. The block replaces direct combinational instruction-memory reads with a multi-cycle, wait-stated access sequence.

Parameters:
- ADDR_W, 32, byte address width for both requesters and the SRAM.
- DATA_W, 32, word width.
- WAIT_CYCLES, 4, number of cycles the SRAM needs per access; legal values are ≥1.
- CNT_W, 4, width of the wait counter; must hold WAIT_CYCLES-1.

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset, asynchronous, active-high.
- if_req, in, 1, instruction fetch request; held until if_ready.
- if_addr, in, ADDR_W, fetch byte address (the PC).
- if_rdata, out, DATA_W, fetched instruction word.
- if_ready, out, 1, one-cycle pulse marking fetch complete.
- d_req, in, 1, data access request; held until d_ready.
- d_we, in, 1, 1 = store, 0 = load.
- d_addr, in, ADDR_W, data byte address.
- d_wdata, in, DATA_W, store data.
- d_rdata, out, DATA_W, load data.
- d_ready, out, 1, one-cycle pulse marking data access complete.
- sram_en, out, 1, SRAM access active.
- sram_we, out, 1, SRAM write enable.
- sram_addr, out, ADDR_W, SRAM word-aligned byte address.
- sram_wdata, out, DATA_W, SRAM write data.
- sram_rdata, in, DATA_W, SRAM read data; valid in the last ACCESS cycle.
- grant_data, out, 1, current or most recent owner; 1 = data, 0 = fetch.

Behaviour:
- FSM states: IDLE, ACCESS, DONE.
- **Reset values** (asynchronous): state = IDLE, counter = 0, all outputs 0, last_owner = fetch.

IDLE:
- Sample the requests.
- If only d_req is high, grant data. If only if_req is high, grant fetch.
- If both are high, grant the requester that is not last_owner. After reset this means data wins first.
- On a grant: latch address with bits [1:0] forced to 0, latch d_we and d_wdata (data grant only), set owner and last_owner, clear counter, go to ACCESS.
- With no request, stay in IDLE and keep sram_en = 0.

ACCESS:
- sram_en = 1 and sram_addr = latched address for the whole state.
- sram_we = latched we for a data grant, 0 for a fetch.
- sram_wdata = latched wdata.
- The counter increments each cycle.
- When counter == WAIT_CYCLES-1, capture sram_rdata into if_rdata or d_rdata (by owner; loads only, stores leave d_rdata unchanged), then go to DONE.
- ACCESS therefore lasts exactly WAIT_CYCLES cycles.

DONE:
- Deassert sram_en and sram_we.
- Assert if_ready or d_ready (by owner) for exactly one cycle.
- Return to IDLE.

Latency and timing:
- A request first seen in IDLE at cycle 0 gives ACCESS in cycles 1..WAIT_CYCLES and ready in cycle WAIT_CYCLES+1.
- A new grant can occur at the earliest in cycle WAIT_CYCLES+2.
- Back-to-back throughput is one access per WAIT_CYCLES+2 cycles.

Boundary conditions:
- if_rdata and d_rdata hold their last captured value until the next capture of the same owner.
- Requester inputs that change during ACCESS are ignored, because all access parameters are latched.
- A request dropped mid-access does not abort the access. It completes and ready still pulses; the requester ignores it.
- if_ready and d_ready are never high in the same cycle.
- Reset mid-access drops sram_en/sram_we immediately, aborts the access, and produces no ready pulse.
- Counter wrap cannot occur: it is cleared on every grant.

Test Plan:
1. **Single fetch.** WAIT_CYCLES=4, SRAM model returns 0xE3A00014 at addr 0; if_req=1 with if_addr=0 at cycle 0 → sram_en high in cycles 1–4 with sram_addr=0 and sram_we=0; if_ready=1 only in cycle 5; if_rdata=0xE3A00014 from cycle 5 on.
2. **Simultaneous requests after reset.** if_req and d_req both high (load) at cycle 0 with d_addr=0x400 → data granted first (grant_data=1, d_ready in cycle 5); fetch granted in cycle 6; if_ready in cycle 11.
3. **Alternation under contention.** Both requests held continuously → grant sequence is data, fetch, data, fetch; no requester is granted twice in a row.
4. **Store.** d_req=1, d_we=1, d_addr=0x403, d_wdata=0x2000 → sram_addr=0x400 and sram_we=1 for 4 cycles; memory[0x400]=0x2000; d_rdata unchanged; d_ready pulses once.
5. **Reset mid-access.** Assert rst in ACCESS cycle 2 → sram_en, sram_we and both ready signals are 0 immediately; after release, a fresh if_req completes in WAIT_CYCLES+1 cycles.
6. **Dropped request and input change.** Drop if_req and change if_addr to 0x40 during ACCESS → SRAM address stays at the originally latched value; if_ready still pulses in cycle 5; FSM returns to IDLE with no new grant.
